// File: rtl/ifu_pkg.sv
// Shared types and constants for the LEGv8 instruction fetch unit.
package ifu_pkg;

  localparam int unsigned ADDR_W_DEF  = 64;
  localparam int unsigned INSTR_W_DEF = 32;
  localparam int unsigned XLEN        = 64;

  localparam logic [31:0] HALT_WORD_DEF = 32'hD440_0000;

  // Instruction field bit positions
  localparam int unsigned OPC_HI = 31;
  localparam int unsigned OPC_LO = 21;
  localparam int unsigned RM_HI  = 20;
  localparam int unsigned RM_LO  = 16;
  localparam int unsigned RN_HI  = 9;
  localparam int unsigned RN_LO  = 5;
  localparam int unsigned RD_HI  = 4;
  localparam int unsigned RD_LO  = 0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC,
    S_HALT,
    S_FAULT
  } ifu_state_e;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Instruction memory req/ack handshake bundle.
interface instr_fetch_unit_if
  import ifu_pkg::*;
#(
  parameter int unsigned ADDR_W  = ADDR_W_DEF,
  parameter int unsigned INSTR_W = INSTR_W_DEF
);
  logic               req;
  logic [ADDR_W-1:0]  addr;
  logic               ack;
  logic [INSTR_W-1:0] rdata;

  modport master (output req, output addr, input ack, input rdata);
  modport slave  (input req, input addr, output ack, output rdata);
endinterface

// File: rtl/instr_field_split.sv
// Splits the latched instruction into its LEGv8 fields and zero-extends it.
module instr_field_split
  import ifu_pkg::*;
(
  input  logic [INSTR_W_DEF-1:0] instr_i,
  output logic [XLEN-1:0]        instruction,
  output logic [10:0]            instr_31_21,
  output logic [4:0]             instr_20_16,
  output logic [4:0]             instr_9_5,
  output logic [4:0]             instr_4_0
);

  // Pure field extraction from the registered instruction word
  always_comb begin
    instruction = XLEN'(instr_i);
    instr_31_21 = instr_i[OPC_HI:OPC_LO];
    instr_20_16 = instr_i[RM_HI:RM_LO];
    instr_9_5   = instr_i[RN_HI:RN_LO];
    instr_4_0   = instr_i[RD_HI:RD_LO];
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// LEGv8 fetch front end: owns the PC, fetches over req/ack, commits nextpc.
// Optional build macro IFU_RETIRE_COUNT_EN adds a 32-bit retire_count output.
module instr_fetch_unit
  import ifu_pkg::*;
#(
  parameter int unsigned          ADDR_W    = ADDR_W_DEF,
  parameter int unsigned          INSTR_W   = INSTR_W_DEF,
  parameter logic [ADDR_W-1:0]    RESET_PC  = '0,
  parameter logic [INSTR_W-1:0]   HALT_WORD = HALT_WORD_DEF
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    enable,
  instr_fetch_unit_if.master      imem,
  input  logic [ADDR_W-1:0]       nextpc,
  output logic [ADDR_W-1:0]       programcounter,
  output logic [XLEN-1:0]         instruction,
  output logic [10:0]             instr_31_21,
  output logic [4:0]              instr_20_16,
  output logic [4:0]              instr_9_5,
  output logic [4:0]              instr_4_0,
  output logic                    instr_valid,
`ifdef IFU_RETIRE_COUNT_EN
  output logic [31:0]             retire_count,
`endif
  output logic                    halted,
  output logic                    fault
);

  ifu_state_e         state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic               req_q, req_d;
  logic               valid_q, valid_d;
  logic               halted_q, halted_d;
  logic               fault_q, fault_d;

  // Next-state, PC commit and instruction capture
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    case (state_q)
      S_IDLE: begin
        if (enable) state_d = S_FETCH;
      end
      S_FETCH: begin
        if (imem.ack) begin
          instr_d = imem.rdata;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (instr_q == HALT_WORD) begin
          state_d = S_HALT;
        end else if (nextpc[1:0] != 2'b00) begin
          state_d = S_FAULT;
        end else begin
          pc_d    = nextpc;
          state_d = enable ? S_FETCH : S_IDLE;
        end
      end
      S_HALT, S_FAULT: state_d = state_q;
      default:         state_d = S_IDLE;
    endcase
    // Outputs are registered decodes of the state being entered
    req_d    = (state_d == S_FETCH);
    valid_d  = (state_d == S_EXEC);
    halted_d = (state_d == S_HALT);
    fault_d  = (state_d == S_FAULT);
  end

  // State, PC and output registers with synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_IDLE;
      pc_q     <= RESET_PC;
      instr_q  <= '0;
      req_q    <= 1'b0;
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      req_q    <= req_d;
      valid_q  <= valid_d;
      halted_q <= halted_d;
      fault_q  <= fault_d;
    end
  end

`ifdef IFU_RETIRE_COUNT_EN
  logic [31:0] retire_q, retire_d;

  // Counts committed instructions, HLT included, wrapping at 2^32
  always_comb begin
    retire_d = retire_q + 32'(valid_q);
  end

  // Retire counter register
  always_ff @(posedge clock) begin
    if (reset) retire_q <= '0;
    else       retire_q <= retire_d;
  end

  assign retire_count = retire_q;
`endif

  assign imem.req       = req_q;
  assign imem.addr      = pc_q;
  assign programcounter = pc_q;
  assign instr_valid    = valid_q;
  assign halted         = halted_q;
  assign fault          = fault_q;

  instr_field_split u_split (
    .instr_i     (instr_q),
    .instruction (instruction),
    .instr_31_21 (instr_31_21),
    .instr_20_16 (instr_20_16),
    .instr_9_5   (instr_9_5),
    .instr_4_0   (instr_4_0)
  );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit (vector table plus corner sequences).
module tb_instr_fetch_unit;
  import ifu_pkg::*;

  localparam logic [31:0] ADD_W  = 32'h8B02_0020;
  localparam logic [31:0] HALT_W = 32'hD440_0000;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic [63:0] nextpc;
  logic [63:0] programcounter;
  logic [63:0] instruction;
  logic [10:0] instr_31_21;
  logic [4:0]  instr_20_16, instr_9_5, instr_4_0;
  logic        instr_valid, halted, fault;
`ifdef IFU_RETIRE_COUNT_EN
  logic [31:0] retire_count;
`endif

  // Memory and CPU model controls
  logic        use_manual = 1'b0;
  logic        ack_m = 1'b0;
  logic [31:0] rdata_m = '0;
  logic [63:0] npc_m = '0;
  logic        npc_ovr_en = 1'b0;
  logic [63:0] npc_ovr = '0;
  int          wait_states = 0;
  int          wcnt = 0;
  logic [31:0] mem [32];

  int n_pass = 0;
  int n_total = 0;

  instr_fetch_unit_if #(.ADDR_W(64), .INSTR_W(32)) imem ();

  instr_fetch_unit dut (
    .clock          (clock),
    .reset          (reset),
    .enable         (enable),
    .imem           (imem),
    .nextpc         (nextpc),
    .programcounter (programcounter),
    .instruction    (instruction),
    .instr_31_21    (instr_31_21),
    .instr_20_16    (instr_20_16),
    .instr_9_5      (instr_9_5),
    .instr_4_0      (instr_4_0),
    .instr_valid    (instr_valid),
`ifdef IFU_RETIRE_COUNT_EN
    .retire_count   (retire_count),
`endif
    .halted         (halted),
    .fault          (fault)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (!imem.req || imem.ack) wcnt <= 0;
    else                       wcnt <= wcnt + 1;
  end

  always_comb begin
    imem.ack   = use_manual ? ack_m : (imem.req && (wcnt >= wait_states));
    imem.rdata = use_manual ? rdata_m : mem[imem.addr[6:2]];
    if (npc_ovr_en)      nextpc = npc_ovr;
    else if (use_manual) nextpc = npc_m;
    else                 nextpc = programcounter + 64'd4;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got no finish, required finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h required %h", name, got, exp);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    enable = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  typedef struct {
    logic        en;
    logic        ack;
    logic [31:0] rdata;
    logic [63:0] npc;
    logic        exp_req;
    logic [63:0] exp_addr;
    logic        exp_valid;
    logic [10:0] exp_op;
  } vec_t;

  vec_t vecs [6];

  int nreq, nval, bad, last_v, first_h;
  logic [63:0] addr0;
  logic stable;

  initial begin
    // Zero-wait fetch sequence: outputs expected in each cycle before the edge
    vecs[0] = '{1'b1, 1'b0, 32'h0,  64'd0, 1'b0, 64'd0, 1'b0, 11'h000};
    vecs[1] = '{1'b1, 1'b1, ADD_W,  64'd0, 1'b1, 64'd0, 1'b0, 11'h000};
    vecs[2] = '{1'b1, 1'b0, 32'h0,  64'd4, 1'b0, 64'd0, 1'b1, 11'h458};
    vecs[3] = '{1'b1, 1'b1, ADD_W,  64'd4, 1'b1, 64'd4, 1'b0, 11'h458};
    vecs[4] = '{1'b0, 1'b0, 32'h0,  64'd8, 1'b0, 64'd4, 1'b1, 11'h458};
    vecs[5] = '{1'b0, 1'b0, 32'h0,  64'd8, 1'b0, 64'd8, 1'b0, 11'h458};
    for (int i = 0; i < 32; i++) mem[i] = ADD_W;

    // Reset state
    do_reset();
    chk("rst_req", 64'(imem.req), 64'd0);
    chk("rst_valid", 64'(instr_valid), 64'd0);
    chk("rst_halted", 64'(halted), 64'd0);
    chk("rst_fault", 64'(fault), 64'd0);
    chk("rst_pc", programcounter, 64'd0);
    chk("rst_instr", instruction, 64'd0);

    // Table-driven zero-wait run
    use_manual = 1'b1;
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("v%0d_req", i), 64'(imem.req), 64'(vecs[i].exp_req));
      chk($sformatf("v%0d_addr", i), imem.addr, vecs[i].exp_addr);
      chk($sformatf("v%0d_valid", i), 64'(instr_valid), 64'(vecs[i].exp_valid));
      chk($sformatf("v%0d_op", i), 64'(instr_31_21), 64'(vecs[i].exp_op));
      enable  = vecs[i].en;
      ack_m   = vecs[i].ack;
      rdata_m = vecs[i].rdata;
      npc_m   = vecs[i].npc;
      @(negedge clock);
    end
    chk("fields_rm", 64'(instr_20_16), 64'd2);
    chk("fields_rn", 64'(instr_9_5), 64'd1);
    chk("fields_rd", 64'(instr_4_0), 64'd0);
    chk("fields_instr", instruction, 64'h0000_0000_8B02_0020);
    use_manual = 1'b0;
    ack_m = 1'b0;

    // Three wait states: req held with stable address for 4 cycles
    do_reset();
    wait_states = 3;
    enable = 1'b1;
    for (int c = 0; c < 10 && !imem.req; c++) @(negedge clock);
    chk("ws_req_seen", 64'(imem.req), 64'd1);
    nreq = 0;
    addr0 = imem.addr;
    stable = 1'b1;
    while (imem.req && nreq < 20) begin
      nreq++;
      if (imem.addr !== addr0) stable = 1'b0;
      enable = 1'b0;
      @(negedge clock);
    end
    chk("ws_req_cycles", 64'(nreq), 64'd4);
    chk("ws_addr_stable", 64'(stable), 64'd1);
    chk("ws_valid_after_ack", 64'(instr_valid), 64'd1);
    @(negedge clock);
    chk("ws_valid_single", 64'(instr_valid), 64'd0);
    chk("ws_pc", programcounter, 64'd4);
    wait_states = 0;

    // HALT fetched at pc=8
    do_reset();
    mem[2] = HALT_W;
    enable = 1'b1;
    nval = 0; bad = 0; last_v = -1; first_h = -1;
    for (int c = 0; c < 40; c++) begin
      if (instr_valid) begin nval++; last_v = c; end
      if (halted && first_h < 0) first_h = c;
      if (halted && imem.req) bad++;
      @(negedge clock);
    end
    chk("halt_valid_count", 64'(nval), 64'd3);
    chk("halt_next_cycle", 64'(first_h), 64'(last_v + 1));
    chk("halt_no_req", 64'(bad), 64'd0);
    chk("halt_pc", programcounter, 64'd8);
    chk("halt_flag", 64'(halted), 64'd1);
    chk("halt_no_fault", 64'(fault), 64'd0);
    chk("halt_instr", instruction, 64'(HALT_W));
    mem[2] = ADD_W;

    // Misaligned nextpc faults and freezes pc
    do_reset();
    npc_ovr_en = 1'b1;
    npc_ovr = 64'h6;
    enable = 1'b1;
    nval = 0; bad = 0;
    for (int c = 0; c < 20; c++) begin
      if (instr_valid) nval++;
      if (fault && imem.req) bad++;
      @(negedge clock);
    end
    chk("fault_flag", 64'(fault), 64'd1);
    chk("fault_no_halt", 64'(halted), 64'd0);
    chk("fault_pc", programcounter, 64'd0);
    chk("fault_valid_count", 64'(nval), 64'd1);
    chk("fault_no_req", 64'(bad), 64'd0);

    // HALT at a misaligned target: halt wins
    do_reset();
    mem[0] = HALT_W;
    enable = 1'b1;
    repeat (10) @(negedge clock);
    chk("prio_halted", 64'(halted), 64'd1);
    chk("prio_fault", 64'(fault), 64'd0);
    mem[0] = ADD_W;
    npc_ovr_en = 1'b0;
    do_reset();
    chk("fault_cleared", 64'(fault), 64'd0);

    // Reset mid-fetch with a late ack
    use_manual = 1'b1;
    ack_m = 1'b0;
    enable = 1'b1;
    @(negedge clock);
    chk("mid_req", 64'(imem.req), 64'd1);
    reset = 1'b1;
    enable = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    ack_m = 1'b1;
    rdata_m = HALT_W;
    @(negedge clock);
    ack_m = 1'b0;
    chk("mid_req_after", 64'(imem.req), 64'd0);
    chk("mid_valid", 64'(instr_valid), 64'd0);
    chk("mid_pc", programcounter, 64'd0);
    chk("mid_instr", instruction, 64'd0);
    @(negedge clock);
    chk("mid_still_idle", 64'(imem.req), 64'd0);
    chk("mid_no_halt", 64'(halted), 64'd0);
    use_manual = 1'b0;

`ifdef IFU_RETIRE_COUNT_EN
    // Five retired instructions ending in HLT
    do_reset();
    chk("rc_reset", 64'(retire_count), 64'd0);
    mem[4] = HALT_W;
    enable = 1'b1;
    repeat (30) @(negedge clock);
    chk("rc_five", 64'(retire_count), 64'd5);
    repeat (10) @(negedge clock);
    chk("rc_hold", 64'(retire_count), 64'd5);
    mem[4] = ADD_W;
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
